uart_tx_cfg: RTL and testbench
==============================

UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, data word width (legal 5..9).
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16, Clock cycles per serial bit (legal 2..65535).
REQ-003 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits per frame (legal 1 or 2).
REQ-005 SHALL use one clock; reset is asynchronous and active-low. Port names are Clock and rst_b.
REQ-006 SHALL have port Clock  input  1  rising-edge system clock.
REQ-007 SHALL have port rst_b  input  1  asynchronous active-low reset.
REQ-008 SHALL have port Data_Bus  input  DATA_BITS  word to transmit.
REQ-009 SHALL have port Data_valid  input  1  Data_Bus holds a word offered for transfer.
REQ-010 SHALL have port Data_ready  output  1  holding register empty; a word can be accepted.
REQ-011 SHALL have port Serial_out  output  1  registered serial line, idle high.
REQ-012 SHALL have port Busy  output  1  frame in progress (FSM not IDLE).

Function
REQ-013 SHALL accept Data_Bus into a one-word holding register on any rising edge where Data_valid=1 and Data_ready=1.
REQ-014 SHALL drive Data_ready = NOT holding-full, decoded from registers only with no combinational path from Data_valid.
REQ-015 SHALL hold Data_valid with Data_ready=0 without any effect; the offered word is neither lost nor duplicated.
REQ-016 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-017 SHALL make each non-IDLE state bit last exactly CLKS_PER_BIT cycles, timed by a baud counter that counts 0..CLKS_PER_BIT-1 and clears on every state or bit change.
REQ-018 SHALL, in IDLE with the holding register full, move to START on the next edge. On that same edge it loads the shift register, clears holding-full and drives Serial_out=0. Latency from accept to the start-bit edge is 1 cycle.
REQ-019 SHALL shift DATA LSB first, DATA_BITS bits; Serial_out equals the current bit.
REQ-020 SHALL skip the PARITY state when PARITY=0. Otherwise it SHALL send one parity bit: even mode gives an even total count of ones over data+parity, odd mode gives an odd total.
REQ-021 SHALL drive Serial_out=1 for STOP_BITS x CLKS_PER_BIT cycles in STOP.
REQ-022 SHALL, at the end of STOP with the holding register full, go directly to START with no idle cycle. With the holding register empty it SHALL go to IDLE with Serial_out=1.
REQ-023 SHALL allow acceptance into the holding register during any state, including the final STOP cycle. A word accepted on the final STOP edge is transmitted after one further cycle via IDLE.
REQ-024 SHALL give frame length (1+DATA_BITS+(PARITY!=0)+STOP_BITS) x CLKS_PER_BIT cycles.
REQ-025 SHALL drive Busy=1 exactly while the FSM is not in IDLE.
REQ-026 SHALL keep Data_Bus changes after acceptance from affecting the frame in progress or the held word.

Reset
REQ-027 SHALL, while rst_b=0, immediately force Serial_out=1, Busy=0, Data_ready=1, FSM to IDLE, baud counter to 0, holding-full to 0 and shift register to 0.
REQ-028 SHALL, on reset mid-frame, abort the frame, discard the held word, and emit no remaining bits after release.
REQ-029 SHALL sit in IDLE after rst_b release until a word is accepted; Data_valid asserted during reset SHALL be ignored.

Verification
REQ-030 SHALL pass this scenario: 8N1, CLKS_PER_BIT=4, send 0x41. Serial_out is 0,1,0,0,0,0,0,1,0,1, each 4 cycles; frame is 40 cycles; Busy is high 40 cycles.
REQ-031 SHALL pass this scenario: 8E1, send 0x41 then 8O1, send 0x41. The parity bit is 0 then 1. Send 0x43 in 8E1: the parity bit is 1; frame is 44 cycles.
REQ-032 SHALL pass this scenario: back-to-back 0x41,0x42,0x43 with Data_valid held high. Two accepts occur before the first stop bit. Frames are contiguous with no idle gap. Data_ready drops while a word is held.
REQ-033 SHALL pass this scenario: assert rst_b=0 during DATA bit 3 of 0x55 with 0xAA held. Serial_out=1 and Busy=0 asynchronously. After release there is no output until a new word is accepted.
REQ-034 SHALL pass this scenario: DATA_BITS=5, STOP_BITS=2, PARITY=0, send 0x1F. The pattern is 0,1,1,1,1,1,1,1; frame is 32 cycles.
REQ-035 SHALL pass this scenario: Data_valid=1 with Data_ready=0 for 10 cycles while the Data_Bus value changes. The value present on the accept edge is the one transmitted.

Source files
------------

// File: rtl/uart_tx_cfg.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_cfg
// Description : Configurable UART transmitter with a one-word holding
//               register. Frame = start, DATA_BITS data (LSB first),
//               optional even/odd parity, STOP_BITS stop bits.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_cfg #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 Clock,
    input  logic                 rst_b,
    input  logic [DATA_BITS-1:0] Data_Bus,
    input  logic                 Data_valid,
    output logic                 Data_ready,
    output logic                 Serial_out,
    output logic                 Busy
);

    localparam logic [15:0] c_BAUD_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [3:0]  c_DATA_LAST  = 4'(DATA_BITS - 1);
    localparam logic [3:0]  c_STOP_LAST  = 4'(STOP_BITS - 1);
    localparam logic        c_HAS_PARITY = (PARITY != 0);
    localparam logic        c_ODD        = (PARITY == 2);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [DATA_BITS-1:0]   r_hold_data;
    logic                   r_hold_full;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_parity;
    logic [15:0]            r_baud_cnt;
    logic [3:0]             r_bit_cnt;
    logic                   r_serial;

    logic                   w_accept;
    logic                   w_baud_end;
    logic                   w_load;
    logic                   w_shift_en;
    logic                   w_bit_clr;
    logic                   w_bit_inc;
    logic                   w_serial_next;

    // Ready depends only on the holding flag, never on Data_valid.
    assign Data_ready = ~r_hold_full;
    assign w_accept   = Data_valid & ~r_hold_full;
    assign w_baud_end = (r_baud_cnt == c_BAUD_LAST);
    assign Busy       = (r_state != S_IDLE);
    assign Serial_out = r_serial;

    // State register.
    always_ff @(posedge Clock or negedge rst_b) begin
        if (!rst_b) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode plus datapath strobes and the next serial level.
    always_comb begin
        w_state_next  = r_state;
        w_load        = 1'b0;
        w_shift_en    = 1'b0;
        w_bit_clr     = 1'b0;
        w_bit_inc     = 1'b0;
        w_serial_next = r_serial;
        case (r_state)
            S_IDLE: begin
                w_serial_next = 1'b1;
                if (r_hold_full) begin
                    w_load        = 1'b1;
                    w_bit_clr     = 1'b1;
                    w_state_next  = S_START;
                    w_serial_next = 1'b0;
                end
            end
            S_START: begin
                if (w_baud_end) begin
                    w_bit_clr     = 1'b1;
                    w_state_next  = S_DATA;
                    w_serial_next = r_shift[0];
                end
            end
            S_DATA: begin
                if (w_baud_end) begin
                    if (r_bit_cnt == c_DATA_LAST) begin
                        w_bit_clr = 1'b1;
                        if (c_HAS_PARITY) begin
                            w_state_next  = S_PARITY;
                            w_serial_next = r_parity;
                        end else begin
                            w_state_next  = S_STOP;
                            w_serial_next = 1'b1;
                        end
                    end else begin
                        // Next bit sits at index 1 before the shift lands.
                        w_shift_en    = 1'b1;
                        w_bit_inc     = 1'b1;
                        w_serial_next = r_shift[1];
                    end
                end
            end
            S_PARITY: begin
                if (w_baud_end) begin
                    w_bit_clr     = 1'b1;
                    w_state_next  = S_STOP;
                    w_serial_next = 1'b1;
                end
            end
            S_STOP: begin
                w_serial_next = 1'b1;
                if (w_baud_end) begin
                    if (r_bit_cnt == c_STOP_LAST) begin
                        w_bit_clr = 1'b1;
                        if (r_hold_full) begin
                            // Chain straight into the next frame.
                            w_load        = 1'b1;
                            w_state_next  = S_START;
                            w_serial_next = 1'b0;
                        end else begin
                            w_state_next  = S_IDLE;
                        end
                    end else begin
                        w_bit_inc = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next  = S_IDLE;
                w_serial_next = 1'b1;
            end
        endcase
    end

    // Holding register: filled on accept, emptied when moved to the shifter.
    always_ff @(posedge Clock or negedge rst_b) begin
        if (!rst_b) begin
            r_hold_data <= '0;
            r_hold_full <= 1'b0;
        end else begin
            if (w_accept) begin
                r_hold_data <= Data_Bus;
            end
            if (w_load) begin
                r_hold_full <= 1'b0;
            end else if (w_accept) begin
                r_hold_full <= 1'b1;
            end
        end
    end

    // Shift register and parity captured together at frame start.
    always_ff @(posedge Clock or negedge rst_b) begin
        if (!rst_b) begin
            r_shift  <= '0;
            r_parity <= 1'b0;
        end else if (w_load) begin
            r_shift  <= r_hold_data;
            r_parity <= (^r_hold_data) ^ c_ODD;
        end else if (w_shift_en) begin
            r_shift  <= r_shift >> 1;
        end
    end

    // Baud and bit counters; baud clears at every bit boundary and in IDLE.
    always_ff @(posedge Clock or negedge rst_b) begin
        if (!rst_b) begin
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
        end else begin
            if ((r_state == S_IDLE) || w_baud_end) begin
                r_baud_cnt <= '0;
            end else begin
                r_baud_cnt <= r_baud_cnt + 16'd1;
            end
            if (w_bit_clr) begin
                r_bit_cnt <= '0;
            end else if (w_bit_inc) begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
            end
        end
    end

    // Registered serial line, idle high.
    always_ff @(posedge Clock or negedge rst_b) begin
        if (!rst_b) begin
            r_serial <= 1'b1;
        end else begin
            r_serial <= w_serial_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_cfg.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_cfg
// Description : Directed self-checking bench for uart_tx_cfg (8N1, 8E1,
//               8O1 and 5N2 instances, CLKS_PER_BIT = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_cfg;

    logic       Clock;
    logic       rst_b;
    logic [7:0] bus;
    logic [3:0] valid;
    logic [3:0] w_ready;
    logic [3:0] w_so;
    logic [3:0] w_busy;

    int         n_err;
    int         n_checks;
    int         n_acc;
    int         acc2_cyc;
    logic       rdy;
    logic       done;

    uart_tx_cfg #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) u_n (
        .Clock(Clock), .rst_b(rst_b), .Data_Bus(bus), .Data_valid(valid[0]),
        .Data_ready(w_ready[0]), .Serial_out(w_so[0]), .Busy(w_busy[0]));
    uart_tx_cfg #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1)) u_e (
        .Clock(Clock), .rst_b(rst_b), .Data_Bus(bus), .Data_valid(valid[1]),
        .Data_ready(w_ready[1]), .Serial_out(w_so[1]), .Busy(w_busy[1]));
    uart_tx_cfg #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1)) u_o (
        .Clock(Clock), .rst_b(rst_b), .Data_Bus(bus), .Data_valid(valid[2]),
        .Data_ready(w_ready[2]), .Serial_out(w_so[2]), .Busy(w_busy[2]));
    uart_tx_cfg #(.DATA_BITS(5), .CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(2)) u_5 (
        .Clock(Clock), .rst_b(rst_b), .Data_Bus(bus[4:0]), .Data_valid(valid[3]),
        .Data_ready(w_ready[3]), .Serial_out(w_so[3]), .Busy(w_busy[3]));

    initial Clock = 1'b0;
    // 10-unit clock; inputs change and outputs are sampled on the falling edge.
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expect pat[bit] on the line for 4 cycles per bit with Busy high, then idle.
    task automatic check_stream(input int sel, input logic [63:0] pat, input int nbits);
        for (int i = 0; i < nbits * 4; i++) begin
            chk($sformatf("frame_bit%0d", i), 8'({w_busy[sel], w_so[sel]}),
                8'({1'b1, pat[i/4]}));
            @(negedge Clock);
        end
        chk("frame_end", 8'({w_busy[sel], w_so[sel]}), 8'b01);
    endtask

    // One isolated word: accepted, held one cycle in IDLE, then the frame.
    task automatic send_one(input int sel, input logic [7:0] w,
                            input logic [63:0] pat, input int nbits);
        bus        = w;
        valid[sel] = 1'b1;
        @(negedge Clock);
        valid[sel] = 1'b0;
        chk("held_idle", 8'({w_busy[sel], w_ready[sel]}), 8'b00);
        @(negedge Clock);
        check_stream(sel, pat, nbits);
    endtask

    initial begin
        n_err    = 0;
        n_checks = 0;
        rst_b    = 1'b0;
        valid    = 4'b0001;
        bus      = 8'h41;

        // Reset values; Data_valid during reset must be ignored.
        repeat (3) @(negedge Clock);
        for (int s = 0; s < 4; s++) begin
            chk("rst_outputs", 8'({w_busy[s], w_so[s], w_ready[s]}), 8'b011);
        end
        rst_b = 1'b1;
        valid = 4'b0000;
        repeat (8) @(negedge Clock);
        chk("idle_after_rst", 8'({w_busy[0], w_so[0], w_ready[0]}), 8'b011);

        // 8N1 0x41: 0,1,0,0,0,0,0,1,0,1
        send_one(0, 8'h41, 64'h282, 10);
        // 8E1 0x41 parity 0, 8O1 0x41 parity 1, 8E1 0x43 parity 1
        send_one(1, 8'h41, 64'h482, 11);
        send_one(2, 8'h41, 64'h682, 11);
        send_one(1, 8'h43, 64'h686, 11);
        // 5N2 0x1F: 0,1,1,1,1,1,1,1
        send_one(3, 8'h1F, 64'h0FE, 8);

        // Accept on the final STOP edge: one IDLE cycle, then the frame.
        bus      = 8'h41;
        valid[0] = 1'b1;
        @(negedge Clock);
        valid[0] = 1'b0;
        repeat (40) @(negedge Clock);
        bus      = 8'h42;
        valid[0] = 1'b1;
        @(negedge Clock);
        valid[0] = 1'b0;
        chk("final_stop_accept", 8'({w_busy[0], w_so[0], w_ready[0]}), 8'b010);
        @(negedge Clock);
        check_stream(0, 64'h284, 10);

        // Back-to-back 0x41,0x42,0x43 with Data_valid held high.
        bus      = 8'h41;
        valid[0] = 1'b1;
        n_acc    = 0;
        acc2_cyc = 0;
        fork
            begin
                @(negedge Clock);
                @(negedge Clock);
                check_stream(0, 64'h286_284_282 & 64'h0 | (64'h282 | (64'h284 << 10) | (64'h286 << 20)), 30);
            end
            begin
                for (int c = 0; c < 200 && n_acc < 3; c++) begin
                    rdy = w_ready[0];
                    @(negedge Clock);
                    if (rdy) begin
                        n_acc++;
                        if (n_acc == 2) acc2_cyc = c + 1;
                        chk("ready_drops_held", 8'(w_ready[0]), 8'd0);
                        if (n_acc == 1) bus = 8'h42;
                        else if (n_acc == 2) bus = 8'h43;
                        else valid[0] = 1'b0;
                    end
                end
                valid[0] = 1'b0;
                chk("three_accepts", 8'(n_acc), 8'd3);
                chk("acc2_before_stop", 8'((acc2_cyc > 0) && (acc2_cyc <= 37)), 8'd1);
            end
        join

        // Stalled offer with a changing bus: only the value on the accept edge counts.
        bus      = 8'h11;
        valid[0] = 1'b1;
        done     = 1'b0;
        fork
            begin
                @(negedge Clock);
                @(negedge Clock);
                check_stream(0, 64'h222 | (64'h244 << 10) | (64'h332 << 20), 30);
            end
            begin
                @(negedge Clock);
                bus = 8'h22;
                @(negedge Clock);
                @(negedge Clock);
                chk("held_22", 8'(w_ready[0]), 8'd0);
                for (int i = 0; i < 10; i++) begin
                    bus = 8'h30 + 8'(i);
                    chk("stall_not_ready", 8'(w_ready[0]), 8'd0);
                    @(negedge Clock);
                end
                bus = 8'h99;
                for (int c = 0; c < 200 && !done; c++) begin
                    rdy = w_ready[0];
                    @(negedge Clock);
                    if (rdy) done = 1'b1;
                end
                valid[0] = 1'b0;
                chk("accept_99", 8'(done), 8'd1);
            end
        join

        // Reset during DATA bit 3 of 0x55 with 0xAA held.
        bus      = 8'h55;
        valid[0] = 1'b1;
        @(negedge Clock);
        bus = 8'hAA;
        @(negedge Clock);
        @(negedge Clock);
        valid[0] = 1'b0;
        chk("aa_held", 8'(w_ready[0]), 8'd0);
        repeat (16) @(negedge Clock);
        chk("mid_bit3", 8'({w_busy[0], w_so[0]}), 8'b10);
        rst_b = 1'b0;
        #1;
        chk("async_rst", 8'({w_busy[0], w_so[0], w_ready[0]}), 8'b011);
        @(negedge Clock);
        @(negedge Clock);
        rst_b = 1'b1;
        for (int i = 0; i < 60; i++) begin
            chk("quiet_after_rst", 8'({w_busy[0], w_so[0]}), 8'b01);
            @(negedge Clock);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
